// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM pipeline stage.
// Accepts one word-addressed request at a time and waits a programmable number
// of cycles. It then performs a byte-lane-masked access and returns the merged
// 32-bit word with a one-cycle rvalid_o pulse. The requester is held with
// stall_o while a request is outstanding.
module dmem_responder #(
   parameter int ADDR_W  = 10,  // word-address bits; 2**ADDR_W words
   parameter int LATENCY = 2    // wait cycles between accept and access, 1..15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_i,
   input  logic [31:0] daddr_i,
   input  logic [3:0]  we_i,
   input  logic [31:0] dwdata_i,
   output logic        stall_o,
   output logic        rvalid_o,
   output logic [31:0] drdata_o,
   output logic        err_o
);

   localparam int         DEPTH    = 2 ** ADDR_W;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Control and latched-request registers
   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:2] addr_q, addr_d;
   logic [3:0]  we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] drdata_q, drdata_d;
   logic        err_q, err_d;

   // Storage and access datapath
   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] word_idx;
   logic              in_range;
   logic              access;
   logic              mem_we;
   logic [31:0]       old_word;
   logic [31:0]       merged_word;

   // The byte offset inside the word is meaningless to a word memory.
   logic unused_daddr_lsbs;
   assign unused_daddr_lsbs = ^daddr_i[1:0];

   assign word_idx = addr_q[ADDR_W+1:2];
   assign in_range = (addr_q[31:ADDR_W+2] == '0);
   assign access   = (state_q == ST_BUSY) && (cnt_q == 4'd0);
   assign mem_we   = access && in_range && (we_q != 4'b0000);
   assign old_word = mem[word_idx];

   // Merge enabled write lanes over the stored word; lane patterns are not policed.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned, which would otherwise infer a latch.
      merged_word = old_word;
      for (int i = 0; i < 4; i++) begin
         if (we_q[i]) merged_word[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   // Next-state logic: IDLE accepts, BUSY counts down then accesses, DONE pulses.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      drdata_d = drdata_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               addr_d  = daddr_i[31:2];
               we_d    = we_i;
               wdata_d = dwdata_i;
               cnt_d   = CNT_LOAD;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (in_range) begin
                  drdata_d = merged_word;
                  err_d    = 1'b0;
               end else begin
                  drdata_d = 32'h0;
                  err_d    = 1'b1;
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // Any req_i seen here waits for the following IDLE cycle.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= '0;
         we_q     <= 4'b0000;
         wdata_q  <= 32'h0;
         drdata_q <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         drdata_q <= drdata_d;
         err_q    <= err_d;
      end
   end

   // Memory write port; a reset during BUSY forces IDLE, so the pending write never fires.
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately left out of reset; clearing it would
      // turn RAM into thousands of flops and contents must survive reset anyway.
      if (mem_we) mem[word_idx] <= merged_word;
   end

   // stall_o follows req_i combinationally in IDLE so the accept cycle is held too.
   assign stall_o  = (state_q == ST_BUSY) || ((state_q == ST_IDLE) && req_i);
   assign rvalid_o = (state_q == ST_DONE);
   assign drdata_o = drdata_q;
   assign err_o    = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder; services the load/store requests that the MEM pipeline stage issues.
- Accepts one request at a time: word address, 4-bit byte-lane write enable, and pre-shifted write data.
- Performs the access after a programmable number of wait cycles, then returns the full 32-bit word with a one-cycle valid pulse.
- Holds the pipeline with stall_o while a request is outstanding. Load extension and lane alignment stay upstream in the MEM stage.

Parameters:
- ADDR_W, 10, word-address bits; memory holds 2**ADDR_W 32-bit words.
- LATENCY, 2, wait cycles between accept and access; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_i  in  1  request valid; held high by requester until rvalid_o.
- daddr_i  in  32  byte address; bits [1:0] ignored.
- we_i  in  4  byte-lane write enables; 4'b0000 = read.
- dwdata_i  in  32  write data, already lane-aligned.
- stall_o  out  1  requester must hold; request outstanding.
- rvalid_o  out  1  one-cycle pulse; response complete.
- drdata_o  out  32  word read at the accessed address.
- err_o  out  1  out-of-range address flag, valid with rvalid_o.

Behaviour:
- Reset is asynchronous, active-high. On reset: state=IDLE, counter=0, latched request cleared, stall_o=0, rvalid_o=0, drdata_o=0, err_o=0.
- Memory array contents are NOT cleared by reset.
- State IDLE:
  - If req_i=1: latch daddr_i, we_i, dwdata_i; counter <= LATENCY-1; go to BUSY.
  - stall_o = req_i, combinational in this state only, so the requester stalls in the accept cycle.
- State BUSY:
  - stall_o=1.
  - If counter != 0: decrement counter.
  - If counter == 0, perform the access using the latched request:
    - Word index = addr[ADDR_W+1:2].
    - Out of range when addr[31:ADDR_W+2] != 0: no write, drdata_o <= 0, err_o <= 1.
    - In range: each byte i with we[i]=1 is written from wdata[8i+7:8i]; other bytes are unchanged.
    - In range: drdata_o <= the post-write merged word, so a read returns the stored word and a store returns the new word.
    - Go to DONE.
- State DONE:
  - rvalid_o=1 and stall_o=0 for exactly one cycle; then go to IDLE.
  - req_i sampled in DONE is ignored; the next request is accepted in the following IDLE cycle.
  - Minimum back-to-back spacing is LATENCY+2 cycles.
- drdata_o and err_o hold their values until the next access completes. err_o is cleared at the completion of any in-range access.
- Latency: accept at cycle 0, access in cycle LATENCY, rvalid_o in cycle LATENCY+1.
- Request inputs are sampled only in IDLE. Changes during BUSY are ignored.
- Reset asserted during BUSY: the pending write is dropped (memory unchanged) and no rvalid_o pulse is produced.
- we_i values that are not a legal lane pattern (e.g. 4'b0101) are written as given. The responder does not police alignment.

Test Plan:
- Reset, LATENCY=2: store daddr=0x10, we=4'hF, wdata=0xDEADBEEF -> stall_o high in cycles 0-2, rvalid_o pulses in cycle 3 with drdata_o=0xDEADBEEF, err_o=0.
- After the previous store: load daddr=0x10, we=0 -> drdata_o=0xDEADBEEF at rvalid_o; load daddr=0x13 returns the same word.
- Byte store daddr=0x10, we=4'b0100, wdata=0x00AA0000 over 0xDEADBEEF -> drdata_o=0xDEAABEEF; a subsequent load confirms it.
- Out of range: daddr=0x00001000 (ADDR_W=10), we=4'hF -> rvalid_o with err_o=1, drdata_o=0; a subsequent load of 0x0 is unchanged; the next in-range access clears err_o.
- Reset pulse during BUSY of a store to 0x20 with wdata=0x12345678 -> no rvalid_o, all outputs 0; a later load of 0x20 returns the prior contents.
- req_i held high continuously across two requests -> second accept occurs in the cycle after the rvalid_o pulse; rvalid_o never asserts on consecutive cycles; LATENCY=1 variant gives rvalid_o in cycle 2.
